// File: rtl/gmii_rx_framer.sv
// gmii_rx_framer
// Receive-side GMII framer in the mac_gmii_rx_clk domain. Removes preamble
// and SFD, assembles nibbles into bytes in 10/100 mode, and presents the frame
// bytes (DA..FCS) as a non-backpressurable AXI-Stream with tlast and a
// bad-frame flag in tuser. Per-frame byte count and preamble errors are
// reported alongside.
//
// Ports
//   clk, rst_n          receive clock, async active-low reset
//   gmii_rxd[7:0]       receive data ([3:0] only in 10/100 mode)
//   gmii_rx_dv          receive data valid
//   gmii_rx_er          receive error
//   speed[1:0]          00=10M, 01=100M, 1x=1000M (quasi-static)
//   m_axis_tdata[7:0]   frame byte
//   m_axis_tvalid       one-cycle beat strobe, no backpressure
//   m_axis_tlast        last byte of frame
//   m_axis_tuser        bad frame, only on the tlast beat
//   stat_frame_len[15:0] frame byte count, updated on the tlast beat
//   stat_bad_preamble   one-cycle pulse on a preamble/SFD error

module gmii_rx_framer #(
    parameter int unsigned MAX_LEN = 1522
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  gmii_rxd,
    input  logic        gmii_rx_dv,
    input  logic        gmii_rx_er,
    input  logic [1:0]  speed,
    output logic [7:0]  m_axis_tdata,
    output logic        m_axis_tvalid,
    output logic        m_axis_tlast,
    output logic        m_axis_tuser,
    output logic [15:0] stat_frame_len,
    output logic        stat_bad_preamble
);

    localparam int unsigned LEN_W   = 16;
    localparam int unsigned BYTE_W  = 8;
    localparam int unsigned NIB_W   = 4;
    localparam logic [LEN_W-1:0] MAX_LEN_C = LEN_W'(MAX_LEN);

    typedef enum logic [1:0] {
        S_DROP     = 2'd0,
        S_IDLE     = 2'd1,
        S_PREAMBLE = 2'd2,
        S_PAYLOAD  = 2'd3
    } state_e;

    state_e              state_q, state_d;
    logic                nib_q, nib_d;
    logic                phase_hi_q, phase_hi_d;
    logic [NIB_W-1:0]    lo_nib_q, lo_nib_d;
    logic [BYTE_W-1:0]   hold_q, hold_d;
    logic                hold_vld_q, hold_vld_d;
    logic                frame_err_q, frame_err_d;
    logic [LEN_W-1:0]    byte_cnt_q, byte_cnt_d;

    logic [BYTE_W-1:0]   tdata_q, tdata_d;
    logic                tvalid_q, tvalid_d;
    logic                tlast_q, tlast_d;
    logic                tuser_q, tuser_d;
    logic [LEN_W-1:0]    frame_len_q, frame_len_d;
    logic                bad_pre_q, bad_pre_d;

    logic                nib_now;
    logic                pre_keep;
    logic                pre_sfd;
    logic [BYTE_W-1:0]   new_byte;

    // 10M and 100M are identical at the GMII nibble level; only speed[1] matters.
    logic                unused_speed0;
    assign unused_speed0 = speed[0];

    // Mode is taken live while IDLE so the first symbol is decoded in the new mode.
    assign nib_now  = (state_q == S_IDLE) ? ~speed[1] : nib_q;
    assign pre_keep = nib_now ? (gmii_rxd[3:0] == 4'h5) : (gmii_rxd == 8'h55);
    assign pre_sfd  = nib_now ? (gmii_rxd[3:0] == 4'hD) : (gmii_rxd == 8'hD5);
    assign new_byte = nib_q ? {gmii_rxd[3:0], lo_nib_q} : gmii_rxd;

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_DROP;
            nib_q       <= 1'b0;
            phase_hi_q  <= 1'b0;
            lo_nib_q    <= '0;
            hold_q      <= '0;
            hold_vld_q  <= 1'b0;
            frame_err_q <= 1'b0;
            byte_cnt_q  <= '0;
            tdata_q     <= '0;
            tvalid_q    <= 1'b0;
            tlast_q     <= 1'b0;
            tuser_q     <= 1'b0;
            frame_len_q <= '0;
            bad_pre_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            nib_q       <= nib_d;
            phase_hi_q  <= phase_hi_d;
            lo_nib_q    <= lo_nib_d;
            hold_q      <= hold_d;
            hold_vld_q  <= hold_vld_d;
            frame_err_q <= frame_err_d;
            byte_cnt_q  <= byte_cnt_d;
            tdata_q     <= tdata_d;
            tvalid_q    <= tvalid_d;
            tlast_q     <= tlast_d;
            tuser_q     <= tuser_d;
            frame_len_q <= frame_len_d;
            bad_pre_q   <= bad_pre_d;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d     = state_q;
        nib_d       = nib_q;
        phase_hi_d  = phase_hi_q;
        lo_nib_d    = lo_nib_q;
        hold_d      = hold_q;
        hold_vld_d  = hold_vld_q;
        frame_err_d = frame_err_q;
        byte_cnt_d  = byte_cnt_q;
        tdata_d     = '0;
        tvalid_d    = 1'b0;
        tlast_d     = 1'b0;
        tuser_d     = 1'b0;
        frame_len_d = frame_len_q;
        bad_pre_d   = 1'b0;

        case (state_q)
            // Discard the rest of any frame until the line goes quiet.
            S_DROP: begin
                if (!gmii_rx_dv) begin
                    state_d = S_IDLE;
                end
            end

            // IDLE decodes its first dv symbol exactly like a preamble symbol.
            S_IDLE, S_PREAMBLE: begin
                if (state_q == S_IDLE) begin
                    nib_d = ~speed[1];
                end
                if (!gmii_rx_dv) begin
                    if (state_q == S_PREAMBLE) begin
                        bad_pre_d = 1'b1;
                        state_d   = S_IDLE;
                    end
                end else if (gmii_rx_er || !(pre_keep || pre_sfd)) begin
                    bad_pre_d = 1'b1;
                    state_d   = S_DROP;
                end else if (pre_sfd) begin
                    state_d     = S_PAYLOAD;
                    phase_hi_d  = 1'b0;
                    hold_vld_d  = 1'b0;
                    frame_err_d = 1'b0;
                    byte_cnt_d  = '0;
                end else begin
                    state_d = S_PREAMBLE;
                end
            end

            // One byte is held back so its tlast can follow from the next dv sample.
            S_PAYLOAD: begin
                if (!gmii_rx_dv) begin
                    state_d = S_IDLE;
                    if (hold_vld_q) begin
                        tvalid_d    = 1'b1;
                        tdata_d     = hold_q;
                        tlast_d     = 1'b1;
                        tuser_d     = frame_err_q | (nib_q & phase_hi_q);
                        frame_len_d = byte_cnt_q;
                    end
                end else begin
                    if (gmii_rx_er) begin
                        frame_err_d = 1'b1;
                    end
                    if (nib_q && !phase_hi_q) begin
                        lo_nib_d   = gmii_rxd[3:0];
                        phase_hi_d = 1'b1;
                    end else begin
                        phase_hi_d = 1'b0;
                        if (byte_cnt_q == MAX_LEN_C) begin
                            // Byte MAX_LEN+1 just completed: close the frame as bad.
                            tvalid_d    = 1'b1;
                            tdata_d     = hold_q;
                            tlast_d     = 1'b1;
                            tuser_d     = 1'b1;
                            frame_len_d = MAX_LEN_C;
                            state_d     = S_DROP;
                        end else begin
                            tvalid_d   = hold_vld_q;
                            tdata_d    = hold_vld_q ? hold_q : 8'h00;
                            hold_d     = new_byte;
                            hold_vld_d = 1'b1;
                            byte_cnt_d = byte_cnt_q + 16'd1;
                        end
                    end
                end
            end

            default: begin
                state_d = S_DROP;
            end
        endcase
    end

    assign m_axis_tdata      = tdata_q;
    assign m_axis_tvalid     = tvalid_q;
    assign m_axis_tlast      = tlast_q;
    assign m_axis_tuser      = tuser_q;
    assign stat_frame_len    = frame_len_q;
    assign stat_bad_preamble = bad_pre_q;

endmodule

// File: tb/tb_gmii_rx_framer.sv
// Testbench for gmii_rx_framer: directed scenarios plus randomized frames,
// checked every cycle against a frame-level expectation queue.

module tb_gmii_rx_framer;

    localparam int MAX_LEN = 64;

    logic        clk;
    logic        rst_n;
    logic [7:0]  gmii_rxd;
    logic        gmii_rx_dv;
    logic        gmii_rx_er;
    logic [1:0]  speed;
    logic [7:0]  m_axis_tdata;
    logic        m_axis_tvalid;
    logic        m_axis_tlast;
    logic        m_axis_tuser;
    logic [15:0] stat_frame_len;
    logic        stat_bad_preamble;

    gmii_rx_framer #(.MAX_LEN(MAX_LEN)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .gmii_rxd          (gmii_rxd),
        .gmii_rx_dv        (gmii_rx_dv),
        .gmii_rx_er        (gmii_rx_er),
        .speed             (speed),
        .m_axis_tdata      (m_axis_tdata),
        .m_axis_tvalid     (m_axis_tvalid),
        .m_axis_tlast      (m_axis_tlast),
        .m_axis_tuser      (m_axis_tuser),
        .stat_frame_len    (stat_frame_len),
        .stat_bad_preamble (stat_bad_preamble)
    );

    typedef struct packed {
        logic [7:0]  data;
        logic        last;
        logic        user;
        logic [15:0] len;
    } beat_t;

    beat_t      exp_q[$];
    logic [7:0] pl[$];

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;
    int exp_bad = 0;
    int bad_seen = 0;
    int beats = 0;
    int lasts = 0;
    int first_cyc = 0;
    int pl_start_cyc = 0;
    bit in_frame = 0;
    logic [7:0]  first_data = 0;
    logic [7:0]  last_data = 0;
    logic        last_user = 0;
    logic [15:0] last_len = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Expected beats of one frame, from its byte count and error conditions.
    function automatic void model_frame(input bit bad, input int n, input bit err, input bit odd);
        int    k;
        beat_t b;
        if (bad) begin
            exp_bad++;
            return;
        end
        k = (n > MAX_LEN) ? MAX_LEN : n;
        for (int i = 0; i < k; i++) begin
            b.data = pl[i];
            b.last = (i == k - 1);
            b.user = b.last && (err || odd || (n > MAX_LEN));
            b.len  = b.last ? 16'(k) : 16'd0;
            exp_q.push_back(b);
        end
    endfunction

    task automatic drv(input logic dv, input logic er, input logic [7:0] d);
        @(posedge clk);
        #1;
        gmii_rx_dv = dv;
        gmii_rx_er = er;
        gmii_rxd   = d;
    endtask

    task automatic send_frame(input logic [1:0] spd, input int npre, input int bad_pos,
                              input logic [7:0] bad_sym, input bit bad_er, input bit no_sfd,
                              input int n, input int er_pos, input bit odd, input int rst_pos,
                              input bit flip, input int gap);
        bit         nib;
        bit         er;
        logic [7:0] s;
        nib   = !spd[1];
        speed = spd;
        model_frame((bad_pos >= 0) || no_sfd, n, (er_pos >= 0) && (er_pos < n), nib && odd);
        for (int i = 0; i < npre; i++) begin
            s  = nib ? {4'($urandom), 4'h5} : 8'h55;
            er = 1'b0;
            if (i == bad_pos) begin
                s  = bad_sym;
                er = bad_er;
            end
            drv(1'b1, er, s);
        end
        if (!no_sfd) begin
            drv(1'b1, 1'b0, nib ? {4'($urandom), 4'hD} : 8'hD5);
            for (int i = 0; i < n; i++) begin
                er = (i == er_pos);
                if (flip && (i == n / 2)) speed = speed ^ 2'b10;
                if (nib) begin
                    drv(1'b1, er, {4'($urandom), pl[i][3:0]});
                    if (i == 0) pl_start_cyc = cyc;
                    drv(1'b1, er, {4'($urandom), pl[i][7:4]});
                end else begin
                    drv(1'b1, er, pl[i]);
                    if (i == 0) pl_start_cyc = cyc;
                end
                if (i == rst_pos) begin
                    rst_n = 1'b0;
                    exp_q.delete();
                end
                if ((rst_pos >= 0) && (i == rst_pos + 3)) rst_n = 1'b1;
            end
            if (odd && nib) drv(1'b1, 1'b0, 8'($urandom));
        end
        for (int i = 0; i < gap; i++) drv(1'b0, 1'b0, 8'($urandom));
    endtask

    task automatic settle(input string name);
        for (int i = 0; i < 4; i++) drv(1'b0, 1'b0, 8'h00);
        chk({name, "_pending_beats"}, 64'(exp_q.size()), 64'd0);
        chk({name, "_bad_preamble_count"}, 64'(bad_seen), 64'(exp_bad));
    endtask

    task automatic fill_ramp(input int n);
        pl.delete();
        for (int i = 0; i < n; i++) pl.push_back(8'(i));
    endtask

    task automatic fill_rand(input int n);
        pl.delete();
        for (int i = 0; i < n; i++) pl.push_back(8'($urandom));
    endtask

    // Per-cycle comparison of the DUT outputs against the expectation queue.
    task automatic mon_loop();
        beat_t e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                chk("outputs_in_reset", 64'({m_axis_tdata, m_axis_tvalid, m_axis_tlast,
                    m_axis_tuser, stat_frame_len, stat_bad_preamble}), 64'd0);
                in_frame = 1'b0;
            end else begin
                if (stat_bad_preamble) bad_seen++;
                if (m_axis_tvalid) begin
                    beats++;
                    if (!in_frame) begin
                        first_cyc  = cyc;
                        first_data = m_axis_tdata;
                    end
                    in_frame = !m_axis_tlast;
                    if (exp_q.size() == 0) begin
                        n_chk++;
                        n_fail++;
                        $display("FAIL unexpected_beat: got data 0x%0h last %0b, expected no beat (cycle %0d)",
                                 m_axis_tdata, m_axis_tlast, cyc);
                    end else begin
                        e = exp_q.pop_front();
                        chk("tdata", 64'(m_axis_tdata), 64'(e.data));
                        chk("tlast", 64'(m_axis_tlast), 64'(e.last));
                        chk("tuser", 64'(m_axis_tuser), 64'(e.user));
                        if (e.last) chk("frame_len", 64'(stat_frame_len), 64'(e.len));
                    end
                    if (m_axis_tlast) begin
                        lasts++;
                        last_data = m_axis_tdata;
                        last_user = m_axis_tuser;
                        last_len  = stat_frame_len;
                    end
                end else begin
                    chk("idle_tlast_tuser", 64'({m_axis_tlast, m_axis_tuser}), 64'd0);
                end
            end
        end
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation exceeded time limit, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int b0;
        int l0;
        int bb0;
        logic [1:0] spd;
        bit   nib;
        int   n;
        int   npre;
        int   bad_pos;
        logic [7:0] bad_sym;
        bit   bad_er;
        bit   no_sfd;
        int   er_pos;
        bit   odd;
        bit   flip;

        rst_n      = 1'b0;
        gmii_rx_dv = 1'b0;
        gmii_rx_er = 1'b0;
        gmii_rxd   = 8'h00;
        speed      = 2'b10;
        fork
            mon_loop();
        join_none
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("post_reset_outputs", 64'({m_axis_tdata, m_axis_tvalid, m_axis_tlast, m_axis_tuser,
            stat_frame_len, stat_bad_preamble}), 64'd0);

        // 1000M good frame
        fill_ramp(64);
        b0 = beats; l0 = lasts;
        send_frame(2'b10, 7, -1, 8'h00, 1'b0, 1'b0, 64, -1, 1'b0, -1, 1'b0, 2);
        settle("gbe_good");
        chk("gbe_beats", 64'(beats - b0), 64'd64);
        chk("gbe_tlast_count", 64'(lasts - l0), 64'd1);
        chk("gbe_first_data", 64'(first_data), 64'h00);
        chk("gbe_last_data", 64'(last_data), 64'h3F);
        chk("gbe_tuser", 64'(last_user), 64'd0);
        chk("gbe_len", 64'(last_len), 64'd64);
        chk("gbe_latency", 64'(first_cyc - pl_start_cyc), 64'd2);

        // 100M good frame, then with a trailing odd nibble
        pl.delete(); pl.push_back(8'h12); pl.push_back(8'h34);
        b0 = beats;
        send_frame(2'b01, 15, -1, 8'h00, 1'b0, 1'b0, 2, -1, 1'b0, -1, 1'b0, 2);
        settle("fe_good");
        chk("fe_beats", 64'(beats - b0), 64'd2);
        chk("fe_first_data", 64'(first_data), 64'h12);
        chk("fe_last_data", 64'(last_data), 64'h34);
        chk("fe_tuser", 64'(last_user), 64'd0);
        chk("fe_len", 64'(last_len), 64'd2);
        b0 = beats;
        send_frame(2'b01, 15, -1, 8'h00, 1'b0, 1'b0, 2, -1, 1'b1, -1, 1'b0, 2);
        settle("fe_odd");
        chk("fe_odd_beats", 64'(beats - b0), 64'd2);
        chk("fe_odd_tuser", 64'(last_user), 64'd1);
        chk("fe_odd_len", 64'(last_len), 64'd2);

        // rx_er on payload byte 10
        fill_ramp(64);
        b0 = beats;
        send_frame(2'b10, 7, -1, 8'h00, 1'b0, 1'b0, 64, 10, 1'b0, -1, 1'b0, 2);
        settle("rx_er");
        chk("rx_er_beats", 64'(beats - b0), 64'd64);
        chk("rx_er_tuser", 64'(last_user), 64'd1);

        // Bad preamble byte 0x57, then a short good frame
        fill_ramp(64);
        b0 = beats; bb0 = bad_seen;
        send_frame(2'b10, 7, 3, 8'h57, 1'b0, 1'b0, 64, -1, 1'b0, -1, 1'b0, 1);
        settle("bad_pre");
        chk("bad_pre_pulses", 64'(bad_seen - bb0), 64'd1);
        chk("bad_pre_beats", 64'(beats - b0), 64'd0);
        fill_ramp(10);
        b0 = beats;
        send_frame(2'b10, 7, -1, 8'h00, 1'b0, 1'b0, 10, -1, 1'b0, -1, 1'b0, 1);
        settle("after_bad_pre");
        chk("after_bad_pre_beats", 64'(beats - b0), 64'd10);
        chk("after_bad_pre_len", 64'(last_len), 64'd10);

        // Overflow: 70 bytes against MAX_LEN=64, then a normal frame
        fill_ramp(70);
        b0 = beats; l0 = lasts;
        send_frame(2'b10, 7, -1, 8'h00, 1'b0, 1'b0, 70, -1, 1'b0, -1, 1'b0, 1);
        settle("overflow");
        chk("ovf_beats", 64'(beats - b0), 64'd64);
        chk("ovf_tlast_count", 64'(lasts - l0), 64'd1);
        chk("ovf_last_data", 64'(last_data), 64'h3F);
        chk("ovf_tuser", 64'(last_user), 64'd1);
        chk("ovf_len", 64'(last_len), 64'd64);
        fill_rand(64);
        b0 = beats;
        send_frame(2'b10, 7, -1, 8'h00, 1'b0, 1'b0, 64, -1, 1'b0, -1, 1'b0, 1);
        settle("after_ovf");
        chk("after_ovf_beats", 64'(beats - b0), 64'd64);
        chk("after_ovf_tuser", 64'(last_user), 64'd0);

        // Reset in the middle of a frame, released while dv is high
        fill_ramp(64);
        l0 = lasts;
        send_frame(2'b10, 7, -1, 8'h00, 1'b0, 1'b0, 64, -1, 1'b0, 20, 1'b0, 2);
        settle("reset_mid");
        chk("reset_mid_tlast_count", 64'(lasts - l0), 64'd0);
        fill_rand(64);
        b0 = beats;
        send_frame(2'b10, 7, -1, 8'h00, 1'b0, 1'b0, 64, -1, 1'b0, -1, 1'b0, 1);
        settle("after_reset");
        chk("after_reset_beats", 64'(beats - b0), 64'd64);
        chk("after_reset_len", 64'(last_len), 64'd64);

        // Back-to-back frames with a single dv=0 cycle between them
        b0 = beats; l0 = lasts;
        fill_rand(64);
        send_frame(2'b10, 7, -1, 8'h00, 1'b0, 1'b0, 64, -1, 1'b0, -1, 1'b0, 1);
        fill_rand(64);
        send_frame(2'b10, 7, -1, 8'h00, 1'b0, 1'b0, 64, -1, 1'b0, -1, 1'b0, 1);
        settle("b2b");
        chk("b2b_beats", 64'(beats - b0), 64'd128);
        chk("b2b_tlast_count", 64'(lasts - l0), 64'd2);
        chk("b2b_len", 64'(last_len), 64'd64);

        // Randomized frames across modes, lengths, errors and gaps
        for (int f = 0; f < 40; f++) begin
            spd  = 2'($urandom);
            nib  = !spd[1];
            n    = $urandom_range(0, 75);
            npre = nib ? $urandom_range(0, 15) : $urandom_range(0, 7);
            bad_pos = -1;
            bad_er  = 1'b0;
            bad_sym = 8'h00;
            no_sfd  = 1'b0;
            if ((npre > 0) && ($urandom_range(0, 9) == 0)) begin
                bad_pos = $urandom_range(0, npre - 1);
                bad_er  = 1'($urandom);
                if (bad_er) begin
                    bad_sym = nib ? {4'($urandom), 4'h5} : 8'h55;
                end else begin
                    do bad_sym = 8'($urandom);
                    while (nib ? ((bad_sym[3:0] == 4'h5) || (bad_sym[3:0] == 4'hD))
                               : ((bad_sym == 8'h55) || (bad_sym == 8'hD5)));
                end
            end else if ((npre > 0) && ($urandom_range(0, 19) == 0)) begin
                no_sfd = 1'b1;
            end
            er_pos = ((n > 0) && ($urandom_range(0, 6) == 0)) ? $urandom_range(0, n - 1) : -1;
            odd    = nib && ($urandom_range(0, 2) == 0);
            flip   = ($urandom_range(0, 4) == 0);
            fill_rand(n);
            send_frame(spd, npre, bad_pos, bad_sym, bad_er, no_sfd, n, er_pos, odd, -1, flip,
                       $urandom_range(1, 3));
        end
        settle("random");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
